mmult_opt_mdc_engine_ctrl: RTL

MMULT_OPT_MDC_ENGINE_CTRL -- requirements
Module: mmult_opt_mdc_engine_ctrl

---
 rtl/mmult_opt_mdc_engine_ctrl_pkg.sv | 27 ++
 rtl/mmult_opt_mdc_engine_ctrl_if.sv | 34 +++
 rtl/mmult_opt_mdc_engine_ctrl.sv | 87 ++++++++
 3 files changed

// File: rtl/mmult_opt_mdc_engine_ctrl_pkg.sv
// Shared types for the mmult_opt_mdc engine controller: command/status
// payloads exchanged with the controller FSM and the engine state encoding.
package mmult_opt_mdc_package;

  localparam int unsigned ENG_CNT_WIDTH = 32;

  typedef enum logic [1:0] {
    ENG_IDLE  = 2'd0,
    ENG_START = 2'd1,
    ENG_RUN   = 2'd2,
    ENG_DONE  = 2'd3
  } state_engine_t;

  typedef struct packed {
    logic                     clear;
    logic                     enable;
    logic                     start;
    logic [ENG_CNT_WIDTH-1:0] cnt_limit_out_r;
  } ctrl_engine_t;

  typedef struct packed {
    logic                     ready;
    logic                     done;
    logic [ENG_CNT_WIDTH-1:0] cnt_out_r;
  } flags_engine_t;

endpackage

// File: rtl/mmult_opt_mdc_engine_ctrl_if.sv
// HLS kernel handshake plus the out_r stream between kernel and streamer sink.
interface mmult_opt_mdc_engine_ctrl_if;

  logic kernel_start_o;
  logic kernel_ready_i;
  logic kernel_done_i;
  logic kernel_out_r_valid_i;
  logic kernel_out_r_ready_o;
  logic sink_out_r_valid_o;
  logic sink_out_r_ready_i;

  // Engine side
  modport master (
    output kernel_start_o,
    output kernel_out_r_ready_o,
    output sink_out_r_valid_o,
    input  kernel_ready_i,
    input  kernel_done_i,
    input  kernel_out_r_valid_i,
    input  sink_out_r_ready_i
  );

  // Kernel / sink side
  modport slave (
    input  kernel_start_o,
    input  kernel_out_r_ready_o,
    input  sink_out_r_valid_o,
    output kernel_ready_i,
    output kernel_done_i,
    output kernel_out_r_valid_i,
    output sink_out_r_ready_i
  );

endinterface

// File: rtl/mmult_opt_mdc_engine_ctrl.sv
// Launch controller for the HLS mmult kernel: sequences ap_start/ap_ready/ap_done,
// passes the out_r stream through and counts delivered output beats.
module mmult_opt_mdc_engine_ctrl
  import mmult_opt_mdc_package::*;
#(
  parameter int unsigned CNT_WIDTH = ENG_CNT_WIDTH
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               test_mode_i,
  input  ctrl_engine_t                       ctrl_i,
  output flags_engine_t                      flags_o,
  mmult_opt_mdc_engine_ctrl_if.master        eng_if
);

  state_engine_t        state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] limit;
  logic                 kernel_start;
  logic                 sink_valid;
  logic                 beat;
  logic                 cnt_sat;
  logic                 idle_or_done;
  logic                 unused_test_mode;

  assign unused_test_mode = test_mode_i;
  assign limit            = CNT_WIDTH'(ctrl_i.cnt_limit_out_r);

  // Zero-latency stream pass-through, gated by enable
  assign sink_valid                  = eng_if.kernel_out_r_valid_i & ctrl_i.enable;
  assign eng_if.sink_out_r_valid_o   = sink_valid;
  assign eng_if.kernel_out_r_ready_o = eng_if.sink_out_r_ready_i & ctrl_i.enable;

  assign kernel_start          = (state_q == ENG_START) & ctrl_i.enable;
  assign eng_if.kernel_start_o = kernel_start;

  assign beat         = sink_valid & eng_if.sink_out_r_ready_i;
  assign cnt_sat      = (cnt_q == limit) | (cnt_q == {CNT_WIDTH{1'b1}});
  assign idle_or_done = (state_q == ENG_IDLE) | (state_q == ENG_DONE);

  // Next state and beat counter; clear overrides everything, enable=0 freezes
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (ctrl_i.clear) begin
      state_d = ENG_IDLE;
      cnt_d   = '0;
    end else begin
      if (beat && !cnt_sat) begin
        cnt_d = cnt_q + CNT_WIDTH'(1);
      end
      if (ctrl_i.enable) begin
        case (state_q)
          ENG_IDLE, ENG_DONE: begin
            if (ctrl_i.start) state_d = ENG_START;
          end
          ENG_START: begin
            if (kernel_start && eng_if.kernel_ready_i) state_d = ENG_RUN;
          end
          ENG_RUN: begin
            if (eng_if.kernel_done_i) state_d = ENG_DONE;
          end
          default: state_d = state_q;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ENG_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Status toward the controller FSM
  always_comb begin
    flags_o           = '0;
    flags_o.ready     = idle_or_done & ~ctrl_i.clear;
    flags_o.done      = (cnt_q == limit) & idle_or_done & (limit != '0);
    flags_o.cnt_out_r = ENG_CNT_WIDTH'(cnt_q);
  end

endmodule
